// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 raster constants and FSM state type
// Holds the default porch/sync/active constants, the derived line and frame
// totals, and the two-state enumeration shared by the timing generator.
package vga_timing_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    typedef enum logic {
        WAIT_LOCK = 1'b0,
        RUN       = 1'b1
    } vga_state_t;

endpackage

// File: rtl/vga_timing_gen_lock_qualifier.sv
// rtl/vga_timing_gen_lock_qualifier.sv - consecutive-cycle PLL lock qualifier
// Ports:
//   clk        in  pixel clock
//   rst        in  synchronous active-high reset
//   pll_locked in  PLL lock flag (already in clk domain)
//   lock_ok    out high once LOCK_WAIT consecutive locked cycles have been seen
//                  and pll_locked is still high
module lock_qualifier #(
    parameter int LOCK_WAIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_locked,
    output logic lock_ok
);

    // Counter only has to reach LOCK_WAIT-1; keep at least one bit.
    localparam int LW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
    localparam logic [LW-1:0] CNT_MAX = LW'(LOCK_WAIT - 1);

    logic [LW-1:0] lock_cnt;

    // Any unlocked cycle throws away all accumulated credit. The count
    // saturates so lock_ok stays up for as long as the PLL stays locked.
    always_ff @(posedge clk) begin
        if (rst || !pll_locked) begin
            lock_cnt <= '0;
        end else if (lock_cnt != CNT_MAX) begin
            lock_cnt <= lock_cnt + 1'b1;
        end
    end

    assign lock_ok = pll_locked && (lock_cnt == CNT_MAX);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster timing generator gated on PLL lock
// Ports:
//   clk         in  25 MHz pixel clock
//   rst         in  synchronous active-high reset
//   pll_locked  in  PLL lock flag (clk domain)
//   hsync       out horizontal sync, active level SYNC_POL
//   vsync       out vertical sync, active level SYNC_POL
//   de          out visible pixel this cycle
//   x, y        out pixel coordinates (0 while waiting for lock)
//   line_start  out pulse at x=0 while running
//   frame_start out pulse at x=0, y=0 while running
//   running     out state is RUN
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int H_FP      = H_FP_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BP      = H_BP_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int V_FP      = V_FP_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BP      = V_BP_DEF,
    parameter bit SYNC_POL  = 1'b0,
    parameter int LOCK_WAIT = 16,
    parameter int CW        = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pll_locked,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic          running
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    vga_state_t    state, state_n;
    logic [CW-1:0] h, v, h_n, v_n;
    logic          lock_ok;

    logic          hsync_n, vsync_n, de_n, line_start_n, frame_start_n, running_n;

    lock_qualifier #(
        .LOCK_WAIT (LOCK_WAIT)
    ) u_lock_qualifier (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .lock_ok    (lock_ok)
    );

    // State and raster counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_LOCK;
            h     <= '0;
            v     <= '0;
        end else begin
            state <= state_n;
            h     <= h_n;
            v     <= v_n;
        end
    end

    // Next state and next counter values. Counters sit at zero outside RUN
    // so the first RUN cycle always starts a fresh frame.
    always_comb begin
        state_n = state;
        h_n     = h;
        v_n     = v;
        if (rst) begin
            state_n = WAIT_LOCK;
            h_n     = '0;
            v_n     = '0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    h_n = '0;
                    v_n = '0;
                    if (lock_ok) begin
                        state_n = RUN;
                    end
                end
                RUN: begin
                    if (!pll_locked) begin
                        state_n = WAIT_LOCK;
                        h_n     = '0;
                        v_n     = '0;
                    end else if (h == H_LAST) begin
                        h_n = '0;
                        v_n = (v == V_LAST) ? '0 : v + 1'b1;
                    end else begin
                        h_n = h + 1'b1;
                    end
                end
                default: begin
                    state_n = WAIT_LOCK;
                    h_n     = '0;
                    v_n     = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next (state, h, v) and registered on the
    // same edge, so every output lines up with the counters of its cycle.
    always_comb begin
        running_n     = (state_n == RUN);
        de_n          = running_n && (h_n < H_ACT) && (v_n < V_ACT);
        hsync_n       = (running_n && (h_n >= HS_START) && (h_n < HS_END)) ? SYNC_POL : !SYNC_POL;
        vsync_n       = (running_n && (v_n >= VS_START) && (v_n < VS_END)) ? SYNC_POL : !SYNC_POL;
        line_start_n  = running_n && (h_n == '0);
        frame_start_n = running_n && (h_n == '0) && (v_n == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hsync       <= !SYNC_POL;
            vsync       <= !SYNC_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            running     <= 1'b0;
        end else begin
            hsync       <= hsync_n;
            vsync       <= vsync_n;
            de          <= de_n;
            x           <= h_n;
            y           <= v_n;
            line_start  <= line_start_n;
            frame_start <= frame_start_n;
            running     <= running_n;
        end
    end

endmodule
